// File: rtl/csr_ctrl_if.sv
// csr_ctrl_if
//   Groups the pipeline-facing signals of the CSR/trap controller.
//   Request side: req_valid/req_ready handshake plus the decoded SYSTEM
//   instruction fields.
//   Response side: resp_valid/resp_ready handshake with the rd writeback
//   fields, and the one-cycle PC redirect pulse.
//   Modports:
//     master - pipeline (drives requests, consumes responses/redirects)
//     slave  - csr_ctrl (accepts requests, produces responses/redirects)
interface csr_ctrl_if #(
  parameter int PC_WIDTH       = 32,
  parameter int CSR_WIDTH      = 32,
  parameter int CSR_ADDR_WIDTH = 12
);
  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_kind;
  logic [2:0]                req_funct3;
  logic [CSR_ADDR_WIDTH-1:0] req_csr_addr;
  logic [4:0]                req_rs1_idx;
  logic [CSR_WIDTH-1:0]      req_rs1_val;
  logic [4:0]                req_rd;
  logic [PC_WIDTH-1:0]       req_pc;

  logic                      resp_valid;
  logic                      resp_ready;
  logic                      rd_we;
  logic [4:0]                rd_idx;
  logic [CSR_WIDTH-1:0]      rd_data;

  logic                      redirect_valid;
  logic [PC_WIDTH-1:0]       redirect_pc;

  modport master (
    output req_valid, req_kind, req_funct3, req_csr_addr, req_rs1_idx,
           req_rs1_val, req_rd, req_pc, resp_ready,
    input  req_ready, resp_valid, rd_we, rd_idx, rd_data,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_csr_addr, req_rs1_idx,
           req_rs1_val, req_rd, req_pc, resp_ready,
    output req_ready, resp_valid, rd_we, rd_idx, rd_data,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_ctrl.sv
// csr_ctrl
//   Initiator side of the CSR/trap interface. Accepts one SYSTEM-class
//   request at a time, performs the CSR read-modify-write or raises a trap /
//   mret toward the CSR file, then returns the rd writeback and any PC
//   redirect to the pipeline.
//   Ports:
//     clk, rst        - clock, synchronous active-high reset
//     pipe            - csr_ctrl_if.slave: request, response, redirect
//     csr_we          - CSR write strobe (single cycle)
//     csr_write_addr  - CSR write address
//     csr_write_data  - CSR write data
//     csr_read_addr   - CSR read address
//     csr_read_data   - combinational read data from the CSR file
//     trap            - 00 none, 01 ecall, 10 illegal, 11 mret (single cycle)
//     pc              - PC of the trapping instruction, sent with trap
module csr_ctrl #(
  parameter int PC_WIDTH       = 32,
  parameter int CSR_WIDTH      = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  csr_ctrl_if.slave                 pipe,
  output logic                      csr_we,
  output logic [CSR_ADDR_WIDTH-1:0] csr_write_addr,
  output logic [CSR_WIDTH-1:0]      csr_write_data,
  output logic [CSR_ADDR_WIDTH-1:0] csr_read_addr,
  input  logic [CSR_WIDTH-1:0]      csr_read_data,
  output logic [1:0]                trap,
  output logic [PC_WIDTH-1:0]       pc
);

  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVEC   = CSR_ADDR_WIDTH'(12'h305);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    TRAP,
    VEC,
    MRET,
    EPC,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]                rs1_idx_q, rs1_idx_d;
  logic [CSR_WIDTH-1:0]      rs1_val_q, rs1_val_d;
  logic [4:0]                rd_q, rd_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [1:0]                code_q, code_d;
  logic [CSR_WIDTH-1:0]      old_q, old_d;
  logic [CSR_WIDTH-1:0]      new_q, new_d;
  logic                      ok_q, ok_d;

  logic [CSR_WIDTH-1:0]      operand;
  logic [CSR_WIDTH-1:0]      new_val;
  logic                      addr_legal;
  logic                      op_legal;
  logic                      need_write;

  // Decode of the latched CSR op, used while in READ. The immediate forms
  // (funct3[2] set) use rs1_idx as a zero-extended 5-bit immediate. Set and
  // clear forms with a zero source skip the write entirely so that reading
  // a CSR never has side effects.
  always_comb begin
    operand = funct3_q[2] ? {{(CSR_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_val_q;
    case (funct3_q[1:0])
      2'b10:   new_val = csr_read_data | operand;
      2'b11:   new_val = csr_read_data & ~operand;
      default: new_val = operand;
    endcase
    addr_legal = (addr_q == ADDR_MSTATUS) || (addr_q == ADDR_MTVEC) ||
                 (addr_q == ADDR_MEPC)    || (addr_q == ADDR_MCAUSE);
    op_legal   = addr_legal && (funct3_q[1:0] != 2'b00);
    need_write = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
  end

  // Next-state and output logic. Everything is Moore-style off state_q,
  // and the whole output set is forced to zero while rst is high so an
  // in-flight request cannot emit a write, trap or redirect while being
  // aborted.
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    rs1_idx_d = rs1_idx_q;
    rs1_val_d = rs1_val_q;
    rd_d      = rd_q;
    pc_d      = pc_q;
    code_d    = code_q;
    old_d     = old_q;
    new_d     = new_q;
    ok_d      = ok_q;

    pipe.req_ready      = 1'b0;
    pipe.resp_valid     = 1'b0;
    pipe.rd_we          = 1'b0;
    pipe.rd_idx         = 5'd0;
    pipe.rd_data        = '0;
    pipe.redirect_valid = 1'b0;
    pipe.redirect_pc    = '0;
    csr_we              = 1'b0;
    csr_write_addr      = '0;
    csr_write_data      = '0;
    csr_read_addr       = '0;
    trap                = 2'b00;
    pc                  = '0;

    case (state_q)
      IDLE: begin
        pipe.req_ready = 1'b1;
        if (pipe.req_valid) begin
          funct3_d  = pipe.req_funct3;
          addr_d    = pipe.req_csr_addr;
          rs1_idx_d = pipe.req_rs1_idx;
          rs1_val_d = pipe.req_rs1_val;
          rd_d      = pipe.req_rd;
          pc_d      = pipe.req_pc;
          old_d     = '0;
          new_d     = '0;
          ok_d      = 1'b0;
          code_d    = 2'b00;
          case (pipe.req_kind)
            2'b00: state_d = READ;
            2'b11: state_d = MRET;
            default: begin
              code_d  = pipe.req_kind;
              state_d = TRAP;
            end
          endcase
        end
      end
      READ: begin
        csr_read_addr = addr_q;
        old_d         = csr_read_data;
        if (!op_legal) begin
          code_d  = 2'b10;
          state_d = TRAP;
        end else begin
          ok_d    = 1'b1;
          new_d   = new_val;
          state_d = need_write ? WRITE : DONE;
        end
      end
      WRITE: begin
        csr_we         = 1'b1;
        csr_write_addr = addr_q;
        csr_write_data = new_q;
        state_d        = DONE;
      end
      TRAP: begin
        trap    = code_q;
        pc      = pc_q;
        state_d = VEC;
      end
      VEC: begin
        // mtvec low bits are mode bits, so the vector is word-aligned here.
        csr_read_addr       = ADDR_MTVEC;
        pipe.redirect_valid = 1'b1;
        pipe.redirect_pc    = {csr_read_data[PC_WIDTH-1:2], 2'b00};
        state_d             = DONE;
      end
      MRET: begin
        trap    = 2'b11;
        pc      = pc_q;
        state_d = EPC;
      end
      EPC: begin
        csr_read_addr       = ADDR_MEPC;
        pipe.redirect_valid = 1'b1;
        pipe.redirect_pc    = csr_read_data[PC_WIDTH-1:0];
        state_d             = DONE;
      end
      DONE: begin
        pipe.resp_valid = 1'b1;
        pipe.rd_idx     = rd_q;
        pipe.rd_data    = old_q;
        pipe.rd_we      = ok_q && (rd_q != 5'd0);
        if (pipe.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      pipe.req_ready      = 1'b0;
      pipe.resp_valid     = 1'b0;
      pipe.rd_we          = 1'b0;
      pipe.rd_idx         = 5'd0;
      pipe.rd_data        = '0;
      pipe.redirect_valid = 1'b0;
      pipe.redirect_pc    = '0;
      csr_we              = 1'b0;
      csr_write_addr      = '0;
      csr_write_data      = '0;
      csr_read_addr       = '0;
      trap                = 2'b00;
      pc                  = '0;
    end
  end

  // State and latched request fields, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      rs1_idx_q <= 5'd0;
      rs1_val_q <= '0;
      rd_q      <= 5'd0;
      pc_q      <= '0;
      code_q    <= 2'b00;
      old_q     <= '0;
      new_q     <= '0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      rs1_idx_q <= rs1_idx_d;
      rs1_val_q <= rs1_val_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
      code_q    <= code_d;
      old_q     <= old_d;
      new_q     <= new_d;
      ok_q      <= ok_d;
    end
  end

endmodule

// File: doc/csr_ctrl.md
Name: csr_ctrl

Overview:
- Initiator side of the CSR/trap interface: sequences SYSTEM-class instructions into read/write/trap commands toward the CSR file, and returns rd writeback plus PC redirects to the pipeline.
- Sits between decode/execute and the CSR file. It drives we, trap, pc, csr_write_addr/data and csr_read_addr, and consumes csr_read_data.
- Multi-cycle: one request in flight, valid/ready handshake on both sides.

Parameters:
- PC_WIDTH, 32, width of pc/redirect buses (matches INSTR_MEM_WIDTH)
- CSR_WIDTH, 32, CSR data width
- CSR_ADDR_WIDTH, 12, CSR address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  controller can accept
- req_kind  in  2  00 CSR op, 01 ecall, 10 illegal, 11 mret
- req_funct3  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_csr_addr  in  CSR_ADDR_WIDTH  target CSR
- req_rs1_idx  in  5  rs1 index / zimm
- req_rs1_val  in  CSR_WIDTH  rs1 value
- req_rd  in  5  destination register
- req_pc  in  PC_WIDTH  PC of instruction
- csr_we  out  1  CSR write strobe
- csr_write_addr  out  CSR_ADDR_WIDTH
- csr_write_data  out  CSR_WIDTH
- csr_read_addr  out  CSR_ADDR_WIDTH
- csr_read_data  in  CSR_WIDTH  combinational read return
- trap  out  2  00 none, 01 ecall, 10 illegal, 11 mret
- pc  out  PC_WIDTH  PC sent with trap
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts
- rd_we  out  1  register writeback enable (qualified by resp_valid)
- rd_idx  out  5
- rd_data  out  CSR_WIDTH  old CSR value
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  PC_WIDTH

Behaviour:
- States: IDLE, READ, WRITE, TRAP, VEC, MRET, EPC, DONE.
- Reset and outputs:
  - rst high: state <= IDLE, all latched fields <= 0.
  - All outputs are 0 while rst is high, including any request mid-flight, which is aborted with no further pulses.
  - req_ready = 1 exactly in IDLE.
- IDLE:
  - Accept on req_valid & req_ready and latch all req_* fields.
  - kind 00 -> READ; kind 01/10 -> TRAP (code = kind); kind 11 -> MRET.
- READ (1 cycle):
  - csr_read_addr = latched addr; old <= csr_read_data.
  - Operand is req_rs1_val, or zimm = zero-extended rs1_idx when funct3[2] = 1.
  - new = operand (RW), old | operand (RS), old & ~operand (RC).
  - Write is needed for RW/RWI always, and for RS/RC variants only when rs1_idx != 0.
  - Address not in {0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause}, or funct3 in {000, 100} -> TRAP with code 10.
  - Otherwise -> WRITE if a write is needed, else DONE.
- WRITE (1 cycle): csr_we = 1 with addr/new data -> DONE.
- TRAP (1 cycle): trap = code, pc = latched pc, csr_we = 0 -> VEC.
- VEC (1 cycle):
  - csr_read_addr = 0x305; redirect_valid = 1.
  - redirect_pc = {csr_read_data[PC_WIDTH-1:2], 2'b00}.
  - -> DONE with rd_we = 0.
- MRET (1 cycle): trap = 11 -> EPC.
- EPC (1 cycle): csr_read_addr = 0x341; redirect_valid = 1; redirect_pc = csr_read_data -> DONE, rd_we = 0.
- DONE:
  - resp_valid = 1; rd_idx = latched rd; rd_data = old.
  - rd_we = 1 only for a successful CSR op with rd != 0.
  - Hold all response outputs stable until resp_ready, then -> IDLE.
  - resp_ready already high on entry means exactly one DONE cycle.
- Protocol invariants:
  - csr_we and trap are never nonzero in the same cycle.
  - Each is a single-cycle pulse.
  - trap is 00 outside TRAP/MRET.
- Latency from accept cycle (cycle 0), resp_ready held high:
  - Write op: resp_valid at cycle 3.
  - Read-only op: cycle 2.
  - Trap/mret: cycle 3.
- A new request is accepted no earlier than the cycle after DONE exits.

Test Plan:
- Reset, then csrrw x5, mtvec, rs1_val = 0x100 -> cycle 2: csr_we = 1, addr 0x305, data 0x100; cycle 3: resp_valid, rd_we = 1, rd_idx = 5, rd_data = old mtvec (0).
- Preload mstatus = 0xF0; csrrc x1, mstatus, rs1_val = 0x30 -> write data 0xC0, rd_data = 0xF0. Then csrrs x2, mstatus, rs1_idx = 0 -> no csr_we pulse, resp at cycle 2, rd_data = 0xC0.
- ecall at pc 0x40 with mtvec = 0x103 -> trap = 01, pc = 0x40 for one cycle; next cycle redirect_valid = 1, redirect_pc = 0x100; rd_we = 0.
- csrrw to 0x7C0 -> no csr_we; trap = 10 with latched pc; redirect to mtvec.
- mret with mepc = 0x80 -> trap = 11 one cycle, then redirect_pc = 0x80; resp_ready held low 3 cycles -> resp_valid and rd_* stable, req_ready = 0 throughout.
- rst asserted during WRITE state -> no csr_we pulse; next cycle IDLE, req_ready = 1, all other outputs 0.
